reorder_buffer: RTL and testbench

//   In-order commit buffer for the out-of-order core. Allocates one entry per

---
 rtl/ooo_pkg.sv | 15 +
 rtl/reorder_buffer.sv | 133 +++++++++++++
 tb/tb_reorder_buffer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ooo_pkg.sv
// Shared types for the out-of-order core: datapath widths and the reorder-buffer entry layout.
package ooo_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  has_dest;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order commit buffer: allocates in program order, completes by tag, and retires the
// oldest finished entry each cycle onto the architectural register file write port.
module reorder_buffer
  import ooo_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned TAG_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  alloc_valid,
  output logic                  alloc_ready,
  input  logic                  alloc_has_dest,
  input  logic [REG_ADDR_W-1:0] alloc_rd,
  output logic [TAG_W-1:0]      alloc_tag,
  input  logic                  wb_valid,
  input  logic [TAG_W-1:0]      wb_tag,
  input  logic [XLEN-1:0]       wb_data,
  input  logic [TAG_W-1:0]      query_tag,
  output logic                  query_done,
  output logic [XLEN-1:0]       query_data,
  input  logic                  flush,
  output logic                  commit_valid,
  output logic [TAG_W-1:0]      commit_tag,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]       reg_write_data,
  output logic [TAG_W:0]        count
);

  localparam logic [TAG_W:0] PtrOne = {{TAG_W{1'b0}}, 1'b1};

  rob_entry_t mem_q [DEPTH];
  rob_entry_t mem_d [DEPTH];

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [TAG_W:0] head_q, head_d;
  logic [TAG_W:0] tail_q, tail_d;

  logic [TAG_W-1:0] head_idx;
  logic [TAG_W-1:0] tail_idx;
  logic             full;
  rob_entry_t       head_e;
  rob_entry_t       query_e;
  logic             alloc_fire;

  assign head_idx   = head_q[TAG_W-1:0];
  assign tail_idx   = tail_q[TAG_W-1:0];
  assign full       = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);
  assign head_e     = mem_q[head_idx];
  assign query_e    = mem_q[query_tag];
  assign alloc_fire = alloc_valid && alloc_ready;

  always_comb begin
    alloc_ready = !full;
    alloc_tag   = tail_idx;
    count       = tail_q - head_q;
  end

  // Commit is purely a function of the stored head entry; a writeback landing this cycle
  // is only visible to commit on the following cycle.
  always_comb begin
    commit_valid   = head_e.valid && head_e.done && !flush;
    reg_write      = commit_valid && head_e.has_dest && (head_e.rd != '0);
    commit_tag     = commit_valid ? head_idx : '0;
    rd             = commit_valid ? head_e.rd : '0;
    reg_write_data = commit_valid ? head_e.data : '0;
  end

  always_comb begin
    query_done = 1'b0;
    query_data = '0;
    if (wb_valid && (wb_tag == query_tag)) begin
      query_done = 1'b1;
      query_data = wb_data;
    end else if (query_e.valid && query_e.done) begin
      query_done = 1'b1;
      query_data = query_e.data;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    head_d = head_q;
    tail_d = tail_q;

    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i].valid = 1'b0;
        mem_d[i].done  = 1'b0;
      end
      head_d = '0;
      tail_d = '0;
    end else begin
      if (wb_valid && mem_q[wb_tag].valid) begin
        mem_d[wb_tag].done = 1'b1;
        mem_d[wb_tag].data = wb_data;
      end
      if (commit_valid) begin
        mem_d[head_idx].valid = 1'b0;
        head_d                = head_q + PtrOne;
      end
      // Alloc only fires when not full, so tail never aliases a live head entry here.
      if (alloc_fire) begin
        mem_d[tail_idx].valid    = 1'b1;
        mem_d[tail_idx].done     = 1'b0;
        mem_d[tail_idx].has_dest = alloc_has_dest;
        mem_d[tail_idx].rd       = alloc_rd;
        mem_d[tail_idx].data     = '0;
        tail_d                   = tail_q + PtrOne;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: ordering, full/wrap, x0/no-dest, bypass, flush and reset.
module tb_reorder_buffer;

  logic        clk;
  logic        reset_n;
  logic        alloc_valid;
  logic        alloc_ready;
  logic        alloc_has_dest;
  logic [4:0]  alloc_rd;
  logic [3:0]  alloc_tag;
  logic        wb_valid;
  logic [3:0]  wb_tag;
  logic [31:0] wb_data;
  logic [3:0]  query_tag;
  logic        query_done;
  logic [31:0] query_data;
  logic        flush;
  logic        commit_valid;
  logic [3:0]  commit_tag;
  logic        reg_write;
  logic [4:0]  rd;
  logic [31:0] reg_write_data;
  logic [4:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  reorder_buffer u_dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .alloc_valid    (alloc_valid),
    .alloc_ready    (alloc_ready),
    .alloc_has_dest (alloc_has_dest),
    .alloc_rd       (alloc_rd),
    .alloc_tag      (alloc_tag),
    .wb_valid       (wb_valid),
    .wb_tag         (wb_tag),
    .wb_data        (wb_data),
    .query_tag      (query_tag),
    .query_done     (query_done),
    .query_data     (query_data),
    .flush          (flush),
    .commit_valid   (commit_valid),
    .commit_tag     (commit_tag),
    .reg_write      (reg_write),
    .rd             (rd),
    .reg_write_data (reg_write_data),
    .count          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled mid-cycle.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_commit(input string tag, input logic v, input logic [3:0] t,
                              input logic w, input logic [4:0] r, input logic [31:0] d);
    check_eq({tag, ".commit_valid"}, 32'(commit_valid), 32'(v));
    check_eq({tag, ".commit_tag"}, 32'(commit_tag), 32'(t));
    check_eq({tag, ".reg_write"}, 32'(reg_write), 32'(w));
    check_eq({tag, ".rd"}, 32'(rd), 32'(r));
    check_eq({tag, ".data"}, reg_write_data, d);
  endtask

  task automatic alloc(input logic hd, input logic [4:0] r, input logic [3:0] exp_tag,
                       input string tag);
    alloc_valid    = 1'b1;
    alloc_has_dest = hd;
    alloc_rd       = r;
    settle();
    check_eq({tag, ".alloc_tag"}, 32'(alloc_tag), 32'(exp_tag));
    step();
    alloc_valid = 1'b0;
  endtask

  initial begin
    reset_n        = 1'b0;
    alloc_valid    = 1'b0;
    alloc_has_dest = 1'b0;
    alloc_rd       = '0;
    wb_valid       = 1'b0;
    wb_tag         = '0;
    wb_data        = '0;
    query_tag      = '0;
    flush          = 1'b0;
    #12;
    check_eq("rst.count", 32'(count), 32'd0);
    check_eq("rst.alloc_ready", 32'(alloc_ready), 32'd1);
    check_commit("rst", 1'b0, 4'd0, 1'b0, 5'd0, 32'd0);
    reset_n = 1'b1;
    step();

    // In-order retirement with out-of-order completion.
    alloc(1'b1, 5'd5, 4'd0, "io0");
    alloc(1'b1, 5'd6, 4'd1, "io1");
    alloc(1'b1, 5'd7, 4'd2, "io2");
    check_eq("io.count3", 32'(count), 32'd3);
    wb_valid = 1'b1; wb_tag = 4'd2; wb_data = 32'h33;
    settle();
    check_eq("io.wb2_no_commit", 32'(commit_valid), 32'd0);
    step();
    wb_tag = 4'd0; wb_data = 32'h11;
    settle();
    check_eq("io.wb0_no_bypass", 32'(commit_valid), 32'd0);
    step();
    wb_valid = 1'b0;
    settle();
    check_commit("io.c0", 1'b1, 4'd0, 1'b1, 5'd5, 32'h11);
    step();
    check_commit("io.hold2", 1'b0, 4'd0, 1'b0, 5'd0, 32'd0);
    check_eq("io.count2", 32'(count), 32'd2);
    wb_valid = 1'b1; wb_tag = 4'd1; wb_data = 32'h22;
    step();
    wb_valid = 1'b0;
    settle();
    check_commit("io.c1", 1'b1, 4'd1, 1'b1, 5'd6, 32'h22);
    step();
    check_commit("io.c2", 1'b1, 4'd2, 1'b1, 5'd7, 32'h33);
    step();
    check_eq("io.empty_count", 32'(count), 32'd0);
    check_eq("io.empty_commit", 32'(commit_valid), 32'd0);

    // Query bypass against a writeback to an unallocated tag (which must be dropped).
    query_tag = 4'd4;
    wb_valid = 1'b1; wb_tag = 4'd4; wb_data = 32'hDEAD;
    settle();
    check_eq("q.bypass_done", 32'(query_done), 32'd1);
    check_eq("q.bypass_data", query_data, 32'hDEAD);
    step();
    wb_valid = 1'b0;
    settle();
    check_eq("q.invalid_ignored", 32'(query_done), 32'd0);
    check_eq("q.invalid_data", query_data, 32'd0);

    // x0 destination and no-destination instructions retire without a register write.
    alloc(1'b1, 5'd0, 4'd3, "x0a");
    alloc(1'b0, 5'd3, 4'd4, "x0b");
    wb_valid = 1'b1; wb_tag = 4'd3; wb_data = 32'hA;
    step();
    wb_tag = 4'd4; wb_data = 32'hB;
    query_tag = 4'd3;
    settle();
    check_commit("x0.c3", 1'b1, 4'd3, 1'b0, 5'd0, 32'hA);
    check_eq("q.stored_done", 32'(query_done), 32'd1);
    check_eq("q.stored_data", query_data, 32'hA);
    step();
    wb_valid = 1'b0;
    settle();
    check_commit("x0.c4", 1'b1, 4'd4, 1'b0, 5'd3, 32'hB);
    step();
    check_eq("x0.count", 32'(count), 32'd0);

    // Flush with a completed head: no commit that cycle, pointers return to zero.
    for (int i = 0; i < 5; i++) begin
      alloc(1'b1, 5'(i + 8), 4'(i + 5), "fl.alloc");
    end
    wb_valid = 1'b1; wb_tag = 4'd5; wb_data = 32'h55;
    step();
    wb_valid = 1'b0;
    settle();
    check_eq("fl.pre_commit", 32'(commit_valid), 32'd1);
    flush = 1'b1;
    alloc_valid = 1'b1; alloc_has_dest = 1'b1; alloc_rd = 5'd9;
    settle();
    check_commit("fl.gated", 1'b0, 4'd0, 1'b0, 5'd0, 32'd0);
    step();
    flush = 1'b0;
    alloc_valid = 1'b0;
    settle();
    check_eq("fl.count", 32'(count), 32'd0);
    check_eq("fl.alloc_tag", 32'(alloc_tag), 32'd0);
    wb_valid = 1'b1; wb_tag = 4'd5; wb_data = 32'h77;
    step();
    wb_valid = 1'b0;
    query_tag = 4'd5;
    settle();
    check_eq("fl.stale_wb", 32'(query_done), 32'd0);
    check_eq("fl.no_commit", 32'(commit_valid), 32'd0);

    // Fill all 16 entries, then retire and reallocate across the wrap.
    for (int i = 0; i < 16; i++) begin
      alloc(1'b1, 5'(i + 1), 4'(i), "fw.alloc");
    end
    check_eq("fw.full_count", 32'(count), 32'd16);
    check_eq("fw.full_ready", 32'(alloc_ready), 32'd0);
    alloc_valid = 1'b1; alloc_rd = 5'd30;
    step();
    alloc_valid = 1'b0;
    check_eq("fw.blocked_count", 32'(count), 32'd16);
    wb_valid = 1'b1; wb_tag = 4'd0; wb_data = 32'h100;
    step();
    wb_tag = 4'd1; wb_data = 32'h101;
    settle();
    check_commit("fw.c0", 1'b1, 4'd0, 1'b1, 5'd1, 32'h100);
    check_eq("fw.full_no_alloc", 32'(alloc_ready), 32'd0);
    step();
    wb_valid = 1'b0;
    settle();
    check_eq("fw.count15", 32'(count), 32'd15);
    check_eq("fw.ready", 32'(alloc_ready), 32'd1);
    check_commit("fw.c1", 1'b1, 4'd1, 1'b1, 5'd2, 32'h101);
    alloc(1'b1, 5'd20, 4'd0, "fw.wrap");
    check_eq("fw.alloc_commit_count", 32'(count), 32'd15);
    check_eq("fw.next_tag", 32'(alloc_tag), 32'd1);
    alloc(1'b1, 5'd21, 4'd1, "fw.wrap2");
    check_eq("fw.refull_count", 32'(count), 32'd16);

    // Asynchronous reset in the middle of a pending commit.
    wb_valid = 1'b1; wb_tag = 4'd2; wb_data = 32'h102;
    step();
    wb_valid = 1'b0;
    settle();
    check_eq("ar.pre_commit", 32'(commit_valid), 32'd1);
    reset_n = 1'b0;
    settle();
    check_eq("ar.count", 32'(count), 32'd0);
    check_eq("ar.alloc_ready", 32'(alloc_ready), 32'd1);
    check_commit("ar", 1'b0, 4'd0, 1'b0, 5'd0, 32'd0);
    step();
    reset_n = 1'b1;
    step();
    check_eq("ar.alloc_tag", 32'(alloc_tag), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete, expected finish before 50000");
    $fatal(1, "timeout");
  end

endmodule
